// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, in_op field
// positions, FSM state encoding and the alignment check.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int OP_STORE = 3;
    localparam int OP_UNS   = 2;
    localparam int OP_SZ_HI = 1;
    localparam int OP_SZ_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // An access is misaligned when the address is not a multiple of its size.
    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
        case (sz)
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            SZ_D:    return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: store data/mask placement onto the doubleword
// bus and load byte extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [7:0]  wmask_o,
    output logic [63:0] wdata_o,
    output logic [63:0] rdata_o
);

    logic [7:0]  base_mask;
    logic [63:0] t;

    always_comb begin
        case (size_i)
            SZ_B:    base_mask = 8'h01;
            SZ_H:    base_mask = 8'h03;
            SZ_W:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
        wmask_o = base_mask << off_i;
        wdata_o = wdata_i << {off_i, 3'b000};
    end

    always_comb begin
        t = rdata_i >> {off_i, 3'b000};
        case (size_i)
            SZ_B:    rdata_o = uns_i ? {56'b0, t[7:0]}  : {{56{t[7]}},  t[7:0]};
            SZ_H:    rdata_o = uns_i ? {48'b0, t[15:0]} : {{48{t[15]}}, t[15:0]};
            SZ_W:    rdata_o = uns_i ? {32'b0, t[31:0]} : {{32{t[31]}}, t[31:0]};
            default: rdata_o = t;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one micro-op at a time, a single memory port cycle per
// aligned access, and a held result on a valid/ready write-back interface.
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_rdata,
    output logic        out_exc
);

    state_e      state_q;
    logic [3:0]  op_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q;
    logic        exc_q;

    logic        accept;
    logic        in_mis;
    logic        is_store;
    logic [7:0]  al_wmask;
    logic [63:0] al_wdata;
    logic [63:0] ld_d;

    lsu_align u_align (
        .size_i  (op_q[OP_SZ_HI:OP_SZ_LO]),
        .uns_i   (op_q[OP_UNS]),
        .off_i   (addr_q[2:0]),
        .wdata_i (wdata_q),
        .rdata_i (mem_rdata),
        .wmask_o (al_wmask),
        .wdata_o (al_wdata),
        .rdata_o (ld_d)
    );

    // RESP can take a new request in the same cycle the result drains.
    assign in_ready = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_RESP) & out_ready));
    assign accept   = in_valid & in_ready;
    assign in_mis   = misaligned(in_op[OP_SZ_HI:OP_SZ_LO], in_addr[2:0]);
    assign is_store = op_q[OP_STORE];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCESS: begin
                    rdata_q <= is_store ? 64'd0 : ld_d;
                    exc_q   <= 1'b0;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (out_ready && !accept) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            if (accept) begin
                op_q    <= in_op;
                addr_q  <= in_addr;
                wdata_q <= in_wdata;
                rdata_q <= '0;
                exc_q   <= in_mis;
                state_q <= in_mis ? ST_RESP : ST_ACCESS;
            end
        end
    end

    assign mem_ce    = (state_q == ST_ACCESS);
    assign mem_we    = mem_ce & is_store;
    assign mem_addr  = mem_ce ? {addr_q[63:3], 3'b000} : 64'd0;
    assign mem_wmask = mem_we ? al_wmask : 8'd0;
    assign mem_wdata = mem_we ? al_wdata : 64'd0;

    assign out_valid = (state_q == ST_RESP);
    assign out_rdata = rdata_q;
    assign out_exc   = exc_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: hand-computed vectors for loads, stores,
// misalignment, backpressure and mid-access reset.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic        mem_ce;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_rdata;
    logic        out_exc;

    int total = 0;
    int bad   = 0;

    lsu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rdata (out_rdata),
        .out_exc   (out_exc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wd);
        in_valid = 1'b1;
        in_op    = op;
        in_addr  = addr;
        in_wdata = wd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_addr = '0; in_wdata = '0;
        mem_rdata = '0; out_ready = 1'b1;
        tick(); tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready_low got %b want 0", in_ready); end
        rst_n = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        total++; if (out_rdata !== 64'd0) begin bad++; $display("FAIL rst_out_rdata got %h want 0", out_rdata); end
        total++; if (out_exc !== 1'b0) begin bad++; $display("FAIL rst_out_exc got %b want 0", out_exc); end
        total++; if ({mem_ce, mem_we, mem_wmask, mem_addr, mem_wdata} !== '0) begin
            bad++; $display("FAIL rst_mem got ce=%b we=%b mask=%h want all 0", mem_ce, mem_we, mem_wmask);
        end
    endtask

    task automatic test_lb();
        mem_rdata = 64'h1122334485667788;
        request(4'b0000, 64'h80000003, 64'd0);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lb_in_ready got %b want 1", in_ready); end
        tick(); in_valid = 1'b0;
        total++; if (mem_ce !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL lb_access got ce=%b valid=%b want 1 0", mem_ce, out_valid);
        end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lb_valid got %b want 1", out_valid); end
        total++; if (out_rdata !== 64'hFFFFFFFFFFFFFF85) begin bad++; $display("FAIL lb_rdata got %h want FFFFFFFFFFFFFF85", out_rdata); end
        total++; if (out_exc !== 1'b0) begin bad++; $display("FAIL lb_exc got %b want 0", out_exc); end
        total++; if (mem_ce !== 1'b0) begin bad++; $display("FAIL lb_ce_resp got %b want 0", mem_ce); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lb_drain got %b want 0", out_valid); end
    endtask

    task automatic test_lhu();
        mem_rdata = 64'h1122334485667788;
        request(4'b0101, 64'h80000006, 64'd0);
        tick(); in_valid = 1'b0;
        total++; if (mem_addr !== 64'h80000000) begin bad++; $display("FAIL lhu_addr got %h want 80000000", mem_addr); end
        total++; if (mem_we !== 1'b0 || mem_wmask !== 8'h00) begin
            bad++; $display("FAIL lhu_we got we=%b mask=%h want 0 00", mem_we, mem_wmask);
        end
        tick();
        total++; if (out_rdata !== 64'h0000000000001122) begin bad++; $display("FAIL lhu_rdata got %h want 1122", out_rdata); end
        tick();
    endtask

    task automatic test_sw();
        mem_rdata = 64'hFFFFFFFFFFFFFFFF;
        request(4'b1010, 64'h80000004, 64'h00000000DEADBEEF);
        tick(); in_valid = 1'b0;
        total++; if (mem_ce !== 1'b1 || mem_we !== 1'b1) begin
            bad++; $display("FAIL sw_ce_we got ce=%b we=%b want 1 1", mem_ce, mem_we);
        end
        total++; if (mem_wmask !== 8'hF0) begin bad++; $display("FAIL sw_mask got %h want F0", mem_wmask); end
        total++; if (mem_wdata !== 64'hDEADBEEF00000000) begin bad++; $display("FAIL sw_wdata got %h want DEADBEEF00000000", mem_wdata); end
        total++; if (mem_addr !== 64'h80000000) begin bad++; $display("FAIL sw_addr got %h want 80000000", mem_addr); end
        tick();
        total++; if (mem_ce !== 1'b0 || out_valid !== 1'b1) begin
            bad++; $display("FAIL sw_resp got ce=%b valid=%b want 0 1", mem_ce, out_valid);
        end
        total++; if (out_rdata !== 64'd0 || out_exc !== 1'b0) begin
            bad++; $display("FAIL sw_result got rdata=%h exc=%b want 0 0", out_rdata, out_exc);
        end
        tick();
    endtask

    task automatic test_sd_sh();
        request(4'b1011, 64'h80000008, 64'h0123456789ABCDEF);
        tick(); in_valid = 1'b0;
        total++; if (mem_wmask !== 8'hFF || mem_wdata !== 64'h0123456789ABCDEF || mem_addr !== 64'h80000008) begin
            bad++; $display("FAIL sd_port got mask=%h wdata=%h addr=%h want FF 0123456789ABCDEF 80000008", mem_wmask, mem_wdata, mem_addr);
        end
        tick(); tick();
        request(4'b1001, 64'h00000012, 64'hFFFFFFFFFFFFA55A);
        tick(); in_valid = 1'b0;
        total++; if (mem_wmask !== 8'h0C || mem_wdata !== 64'hFFFFFFFFA55A0000) begin
            bad++; $display("FAIL sh_port got mask=%h wdata=%h want 0C FFFFFFFFA55A0000", mem_wmask, mem_wdata);
        end
        tick(); tick();
    endtask

    task automatic test_misaligned();
        int ce_seen = 0;
        request(4'b0010, 64'h80000002, 64'd0);
        tick(); in_valid = 1'b0;
        if (mem_ce) ce_seen++;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mis_valid got %b want 1", out_valid); end
        total++; if (out_exc !== 1'b1) begin bad++; $display("FAIL mis_exc got %b want 1", out_exc); end
        total++; if (out_rdata !== 64'd0) begin bad++; $display("FAIL mis_rdata got %h want 0", out_rdata); end
        tick();
        if (mem_ce) ce_seen++;
        total++; if (ce_seen !== 0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL mis_no_ce got ce_cycles=%0d valid=%b want 0 0", ce_seen, out_valid);
        end
        // byte accesses at odd addresses are always aligned
        mem_rdata = 64'h00000000000080FF;
        request(4'b0100, 64'h80000001, 64'd0);
        tick(); in_valid = 1'b0;
        total++; if (mem_ce !== 1'b1) begin bad++; $display("FAIL lbu_odd_ce got %b want 1", mem_ce); end
        tick();
        total++; if (out_rdata !== 64'h80 || out_exc !== 1'b0) begin
            bad++; $display("FAIL lbu_odd got rdata=%h exc=%b want 80 0", out_rdata, out_exc);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int ce_cnt = 0;
        mem_rdata = 64'hCAFEBABE12345678;
        out_ready = 1'b0;
        request(4'b0111, 64'h80000010, 64'd0);
        tick(); in_valid = 1'b0;
        if (mem_ce) ce_cnt++;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (mem_ce) ce_cnt++;
            total++; if (out_valid !== 1'b1 || out_rdata !== 64'hCAFEBABE12345678) begin
                bad++; $display("FAIL bp_hold%0d got valid=%b rdata=%h want 1 CAFEBABE12345678", i, out_valid, out_rdata);
            end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d got %b want 0", i, in_ready); end
            tick();
        end
        total++; if (ce_cnt !== 1) begin bad++; $display("FAIL bp_ce_count got %0d want 1", ce_cnt); end
        out_ready = 1'b1;
        request(4'b0100, 64'h80000001, 64'd0);
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_release got ready=%b valid=%b want 1 1", in_ready, out_valid);
        end
        tick(); in_valid = 1'b0;
        total++; if (mem_ce !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_access got ce=%b valid=%b want 1 0", mem_ce, out_valid);
        end
        tick();
        total++; if (out_rdata !== 64'h56) begin bad++; $display("FAIL b2b_rdata got %h want 56", out_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        request(4'b0011, 64'h80000020, 64'd0);
        tick(); in_valid = 1'b0;
        total++; if (mem_ce !== 1'b1) begin bad++; $display("FAIL rmid_ce got %b want 1", mem_ce); end
        rst_n = 1'b0;
        tick();
        total++; if (mem_ce !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL rmid_state got ce=%b valid=%b ready=%b want 0 0 0", mem_ce, out_valid, in_ready);
        end
        total++; if (out_rdata !== 64'd0 || out_exc !== 1'b0 || mem_addr !== 64'd0) begin
            bad++; $display("FAIL rmid_vals got rdata=%h exc=%b addr=%h want 0 0 0", out_rdata, out_exc, mem_addr);
        end
        rst_n = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rmid_after got valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lhu();
        test_sw();
        test_sd_sh();
        test_misaligned();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
